// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared widths, sizes and FSM state encoding for the conv sequencer
package nn_pkg;

    localparam int NN_DATA_W    = 16;
    localparam int NN_FADDR_W   = 10;
    localparam int NN_IADDR_W   = 9;
    localparam int NN_OADDR_W   = 3;
    localparam int NN_VEC_LEN   = 64;
    localparam int NN_OUT_COUNT = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_WAIT_RES = 3'd3,
        ST_WRITE    = 3'd4,
        ST_DONE     = 3'd5
    } seq_state_t;

    // Counter width for a count of n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_index_counter.sv
// rtl/seq_index_counter.sv - element (k) and output (o) index counters with terminal flags
module seq_index_counter
    import nn_pkg::*;
#(
    parameter int VEC_LEN   = NN_VEC_LEN,
    parameter int OUT_COUNT = NN_OUT_COUNT,
    parameter int K_W       = cnt_w(VEC_LEN),
    parameter int O_W       = cnt_w(OUT_COUNT)
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_k_clr,
    input  logic           i_k_inc,
    input  logic           i_o_clr,
    input  logic           i_o_inc,
    output logic [K_W-1:0] o_k,
    output logic [O_W-1:0] o_o,
    output logic           o_k_last,
    output logic           o_o_last
);

    logic [K_W-1:0] r_k;
    logic [O_W-1:0] r_o;
    logic           w_k_last;
    logic           w_o_last;

    assign w_k_last = (r_k == K_W'(VEC_LEN - 1));
    assign w_o_last = (r_o == O_W'(OUT_COUNT - 1));

    // k wraps to 0 after the last element so the next row starts clean.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_k <= '0;
        end else if (i_k_clr) begin
            r_k <= '0;
        end else if (i_k_inc) begin
            r_k <= w_k_last ? '0 : r_k + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_o <= '0;
        end else if (i_o_clr) begin
            r_o <= '0;
        end else if (i_o_inc) begin
            r_o <= w_o_last ? '0 : r_o + 1'b1;
        end
    end

    assign o_k      = r_k;
    assign o_o      = r_o;
    assign o_k_last = w_k_last;
    assign o_o_last = w_o_last;

endmodule

// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - control FSM streaming dim/bvm operands into the MAC and writing dom
module conv_sequencer
    import nn_pkg::*;
#(
    parameter int DATA_W    = NN_DATA_W,
    parameter int VEC_LEN   = NN_VEC_LEN,
    parameter int OUT_COUNT = NN_OUT_COUNT,
    parameter int IN_BASE   = 0,
    parameter int FILT_BASE = 0,
    parameter int FADDR_W   = NN_FADDR_W,
    parameter int IADDR_W   = NN_IADDR_W,
    parameter int OADDR_W   = NN_OADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               xxx__dut__go,
    output logic               dut__xxx__finish,
    output logic [FADDR_W-1:0] dut__bvm__address,
    output logic               dut__bvm__enable,
    output logic               dut__bvm__write,
    input  logic [DATA_W-1:0]  bvm__dut__data,
    output logic [IADDR_W-1:0] dut__dim__address,
    output logic               dut__dim__enable,
    output logic               dut__dim__write,
    input  logic [DATA_W-1:0]  dim__dut__data,
    output logic [OADDR_W-1:0] dut__dom__address,
    output logic [DATA_W-1:0]  dut__dom__data,
    output logic               dut__dom__enable,
    output logic               dut__dom__write,
    output logic [DATA_W-1:0]  mac_a,
    output logic [DATA_W-1:0]  mac_b,
    output logic               mac_valid,
    output logic               mac_first,
    output logic               mac_last,
    input  logic [DATA_W-1:0]  mac_result,
    input  logic               mac_result_valid
);

    localparam int K_W = cnt_w(VEC_LEN);
    localparam int O_W = cnt_w(OUT_COUNT);

    seq_state_t      r_state;
    seq_state_t      w_next;
    logic [K_W-1:0]  w_k;
    logic [O_W-1:0]  w_o;
    logic            w_k_last;
    logic            w_o_last;
    logic            w_k_clr;
    logic            w_k_inc;
    logic            w_o_clr;
    logic            w_o_inc;
    logic            w_latch;
    logic            w_fetch;
    logic            r_mac_valid;
    logic            r_mac_first;
    logic            r_mac_last;
    logic [DATA_W-1:0] r_result;

    seq_index_counter #(
        .VEC_LEN   (VEC_LEN),
        .OUT_COUNT (OUT_COUNT),
        .K_W       (K_W),
        .O_W       (O_W)
    ) u_idx (
        .i_clk    (clk),
        .i_rst_n  (reset),
        .i_k_clr  (w_k_clr),
        .i_k_inc  (w_k_inc),
        .i_o_clr  (w_o_clr),
        .i_o_inc  (w_o_inc),
        .o_k      (w_k),
        .o_o      (w_o),
        .o_k_last (w_k_last),
        .o_o_last (w_o_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_k_clr = 1'b0;
        w_k_inc = 1'b0;
        w_o_clr = 1'b0;
        w_o_inc = 1'b0;
        w_latch = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (xxx__dut__go) begin
                    w_next  = ST_FETCH;
                    w_k_clr = 1'b1;
                    w_o_clr = 1'b1;
                end
            end
            ST_FETCH: begin
                w_k_inc = 1'b1;
                if (w_k_last) begin
                    w_next = ST_DRAIN;
                end
            end
            // The final operand is on the MAC bus this cycle.
            ST_DRAIN: begin
                if (r_mac_last) begin
                    w_next = ST_WAIT_RES;
                end
            end
            ST_WAIT_RES: begin
                if (mac_result_valid) begin
                    w_latch = 1'b1;
                    w_next  = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (w_o_last) begin
                    w_next = ST_DONE;
                end else begin
                    w_o_inc = 1'b1;
                    w_k_clr = 1'b1;
                    w_next  = ST_FETCH;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Issue flags trail the read strobes by one cycle to line up with SRAM data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mac_valid <= 1'b0;
            r_mac_first <= 1'b0;
            r_mac_last  <= 1'b0;
        end else begin
            r_mac_valid <= w_fetch;
            r_mac_first <= w_fetch && (w_k == '0);
            r_mac_last  <= w_fetch && w_k_last;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_result <= '0;
        end else if (w_latch) begin
            r_result <= mac_result;
        end
    end

    assign w_fetch = (r_state == ST_FETCH);

    assign dut__bvm__enable  = w_fetch;
    assign dut__dim__enable  = w_fetch;
    assign dut__bvm__write   = 1'b0;
    assign dut__dim__write   = 1'b0;
    assign dut__bvm__address = w_fetch ? (FADDR_W'(FILT_BASE) + FADDR_W'(w_o) * FADDR_W'(VEC_LEN)
                                          + FADDR_W'(w_k)) : '0;
    assign dut__dim__address = w_fetch ? (IADDR_W'(IN_BASE) + IADDR_W'(w_k)) : '0;

    assign dut__dom__enable  = (r_state == ST_WRITE);
    assign dut__dom__write   = (r_state == ST_WRITE);
    assign dut__dom__address = OADDR_W'(w_o);
    assign dut__dom__data    = r_result;

    assign dut__xxx__finish  = (r_state == ST_IDLE) || (r_state == ST_DONE);

    assign mac_valid = r_mac_valid;
    assign mac_first = r_mac_first;
    assign mac_last  = r_mac_last;
    assign mac_a     = r_mac_valid ? dim__dut__data : '0;
    assign mac_b     = r_mac_valid ? bvm__dut__data : '0;

endmodule

// File: tb/tb_conv_sequencer.sv
// tb/tb_conv_sequencer.sv - randomized bench with SRAM/MAC models and a run-level reference
module tb_conv_sequencer;

    localparam int VL = 64;
    localparam int OC = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        go = 1'b0;
    logic        finish;
    logic [9:0]  bvm_addr;
    logic        bvm_en, bvm_wr;
    logic [15:0] bvm_q = '0;
    logic [8:0]  dim_addr;
    logic        dim_en, dim_wr;
    logic [15:0] dim_q = '0;
    logic [2:0]  dom_addr;
    logic [15:0] dom_data;
    logic        dom_en, dom_wr;
    logic [15:0] mac_a, mac_b;
    logic        mac_valid, mac_first, mac_last;
    logic [15:0] mac_result;
    logic        mac_result_valid;

    int total = 0;
    int bad = 0;

    logic [15:0] dim_mem [512];
    logic [15:0] bvm_mem [1024];
    logic [15:0] dom_mem [OC];
    logic [15:0] exp_dom [OC];
    logic [15:0] saved   [OC];
    int n_writes = 0;

    int q_faddr[$], q_iaddr[$], q_a[$], q_b[$], q_fl[$], q_waddr[$], q_wdata[$];

    always #5 clk = ~clk;

    conv_sequencer dut (
        .clk               (clk),
        .reset             (reset),
        .xxx__dut__go      (go),
        .dut__xxx__finish  (finish),
        .dut__bvm__address (bvm_addr),
        .dut__bvm__enable  (bvm_en),
        .dut__bvm__write   (bvm_wr),
        .bvm__dut__data    (bvm_q),
        .dut__dim__address (dim_addr),
        .dut__dim__enable  (dim_en),
        .dut__dim__write   (dim_wr),
        .dim__dut__data    (dim_q),
        .dut__dom__address (dom_addr),
        .dut__dom__data    (dom_data),
        .dut__dom__enable  (dom_en),
        .dut__dom__write   (dom_wr),
        .mac_a             (mac_a),
        .mac_b             (mac_b),
        .mac_valid         (mac_valid),
        .mac_first         (mac_first),
        .mac_last          (mac_last),
        .mac_result        (mac_result),
        .mac_result_valid  (mac_result_valid)
    );

    // SRAMs with one-cycle read latency.
    always @(posedge clk) begin
        if (dim_en) dim_q <= dim_mem[dim_addr];
        if (bvm_en) bvm_q <= bvm_mem[bvm_addr];
    end

    // MAC datapath with programmable result latency.
    int          lat = 3;
    int          cnt = 0;
    logic [15:0] acc = '0;
    logic [15:0] res = '0;
    logic        rv = 1'b0;
    logic        spur = 1'b0;

    always @(posedge clk) begin
        rv <= 1'b0;
        if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                rv  <= 1'b1;
                res <= acc;
            end
        end
        if (mac_valid) begin
            acc <= (mac_first ? 16'h0 : acc) + mac_a * mac_b;
            if (mac_last) cnt <= lat;
        end
    end

    assign mac_result_valid = rv | spur;
    assign mac_result       = spur ? 16'hBEEF : res;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference for one run: every read address, operand and dom write in order.
    task automatic load_model();
        logic [15:0] s;
        for (int o = 0; o < OC; o++) begin
            s = '0;
            for (int k = 0; k < VL; k++) begin
                q_faddr.push_back(o * VL + k);
                q_iaddr.push_back(k);
                q_a.push_back(int'(dim_mem[k]));
                q_b.push_back(int'(bvm_mem[o * VL + k]));
                q_fl.push_back((k == 0 ? 1 : 0) | (k == VL - 1 ? 2 : 0));
                s = s + 16'(dim_mem[k] * bvm_mem[o * VL + k]);
            end
            exp_dom[o] = s;
            q_waddr.push_back(o);
            q_wdata.push_back(int'(s));
        end
    endtask

    task automatic clear_model();
        q_faddr.delete(); q_iaddr.delete(); q_a.delete(); q_b.delete();
        q_fl.delete(); q_waddr.delete(); q_wdata.delete();
    endtask

    int  en_run = 0;
    int  mv_run = 0;
    bit  prev_last_wr = 0;

    always @(negedge clk) begin
        if (!reset) begin
            en_run = 0;
            mv_run = 0;
            prev_last_wr = 0;
        end else begin
            chk("bvm_write_tied", bvm_wr, 0);
            chk("dim_write_tied", dim_wr, 0);
            chk("enable_pair", dim_en, bvm_en);
            if (prev_last_wr) chk("finish_after_last_write", finish, 1);
            prev_last_wr = 0;
            if (bvm_en) begin
                chk("enable_vs_dom_overlap", dom_en, 0);
                if (q_faddr.size() == 0) chk("unexpected_read", 1, 0);
                else begin
                    chk("bvm_addr", bvm_addr, q_faddr.pop_front());
                    chk("dim_addr", dim_addr, q_iaddr.pop_front());
                end
                en_run++;
            end else begin
                if (en_run != 0) chk("read_burst_len", en_run, VL);
                en_run = 0;
            end
            if (mac_valid) begin
                if (q_a.size() == 0) chk("unexpected_mac_valid", 1, 0);
                else begin
                    chk("mac_a", mac_a, q_a.pop_front());
                    chk("mac_b", mac_b, q_b.pop_front());
                    chk("mac_first_last", {30'd0, mac_last, mac_first}, q_fl.pop_front());
                end
                mv_run++;
            end else begin
                if (mv_run != 0) chk("mac_valid_burst_len", mv_run, VL);
                mv_run = 0;
            end
            if (dom_en) begin
                chk("dom_write_strobe", dom_wr, 1);
                if (q_waddr.size() == 0) chk("unexpected_dom_write", 1, 0);
                else begin
                    chk("dom_addr", dom_addr, q_waddr.pop_front());
                    chk("dom_data", dom_data, q_wdata.pop_front());
                    prev_last_wr = (q_waddr.size() == 0);
                end
                dom_mem[dom_addr] = dom_data;
                n_writes++;
            end
        end
    end

    task automatic run(input int l, input bit noise);
        int w0;
        int c;
        bit done;
        lat  = l;
        load_model();
        w0   = n_writes;
        done = 0;
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        chk("first_enable_after_go", bvm_en, 1);
        chk("finish_drops", finish, 0);
        for (c = 1; c < 4000 && !done; c++) begin
            @(negedge clk);
            go = noise && (c == 10 || c == 75);
            if (finish) done = 1;
        end
        go = 1'b0;
        chk("run_completed", done, 1);
        chk("write_count", n_writes - w0, OC);
        chk("model_drained", q_faddr.size() + q_a.size() + q_waddr.size(), 0);
    endtask

    initial begin
        int w;
        for (int i = 0; i < 512; i++) dim_mem[i] = '0;
        for (int i = 0; i < 1024; i++) bvm_mem[i] = '0;
        for (int i = 0; i < OC; i++) dom_mem[i] = '0;
        for (int k = 0; k < VL; k++) dim_mem[k] = 16'(k + 1);
        for (int o = 0; o < OC; o++)
            for (int k = 0; k < VL; k++) bvm_mem[o * VL + k] = 16'(o + 1);

        #2;
        chk("rst_finish", finish, 1);
        chk("rst_enables", {29'd0, bvm_en, dim_en, dom_en}, 0);
        chk("rst_mac_flags", {29'd0, mac_valid, mac_first, mac_last}, 0);
        chk("rst_addrs", {bvm_addr, dim_addr, dom_addr}, 0);
        chk("rst_dom_data", dom_data, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_finish", finish, 1);

        run(3, 0);
        chk("model_pin_dom0", exp_dom[0], 16'd2080);
        chk("model_pin_dom7", exp_dom[7], 16'd16640);
        chk("dom0_literal", dom_mem[0], 16'd2080);
        chk("dom3_literal", dom_mem[3], 16'd8320);
        chk("dom7_literal", dom_mem[7], 16'd16640);

        @(negedge clk);
        run(3, 0);
        chk("b2b_dom5_literal", dom_mem[5], 16'd12480);

        w = n_writes;
        @(negedge clk); spur = 1'b1;
        @(negedge clk); spur = 1'b0;
        repeat (5) @(negedge clk);
        chk("spurious_result_no_write", n_writes, w);
        chk("spurious_finish_held", finish, 1);

        for (int i = 0; i < VL; i++) dim_mem[i] = 16'($urandom);
        for (int i = 0; i < OC * VL; i++) bvm_mem[i] = 16'($urandom);
        run(1, 0);
        for (int o = 0; o < OC; o++) saved[o] = dom_mem[o];
        repeat (2) @(negedge clk);
        run(20, 1);
        for (int o = 0; o < OC; o++) chk("lat1_vs_lat20", dom_mem[o], saved[o]);

        lat = 4;
        load_model();
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        repeat (20) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_enables_low", {30'd0, bvm_en, dim_en}, 0);
        chk("abort_finish", finish, 1);
        chk("abort_mac_valid", mac_valid, 0);
        clear_model();
        w = n_writes;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (60) @(negedge clk);
        chk("no_write_after_abort", n_writes, w);
        chk("idle_after_abort", finish, 1);

        for (int i = 0; i < VL; i++) dim_mem[i] = 16'($urandom);
        run(5, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
